// File: rtl/boss_path_move_if.sv
// Boss motion bus: control-side triggers in, sprite position and mode out.
interface boss_path_move_if #(
    parameter int PIXEL_WIDTH = 11
);
    logic                          enable;
    logic                          startOfFrame;
    logic                          border_collision;
    logic [3:0]                    HitEdgeCode;
    logic                          switch_direction_pulse;
    logic                          random_axis;
    logic                          dive_request;
    logic signed [PIXEL_WIDTH-1:0] topLeftX;
    logic signed [PIXEL_WIDTH-1:0] topLeftY;
    logic [1:0]                    mode;
    logic                          diving;

    modport master (
        output enable, startOfFrame, border_collision, HitEdgeCode,
               switch_direction_pulse, random_axis, dive_request,
        input  topLeftX, topLeftY, mode, diving
    );

    modport slave (
        input  enable, startOfFrame, border_collision, HitEdgeCode,
               switch_direction_pulse, random_axis, dive_request,
        output topLeftX, topLeftY, mode, diving
    );
endinterface

// File: rtl/boss_path_move.sv
// Boss sprite motion with sub-pixel position, border bounce and a cruise/dive/return FSM.
// Optional cruise speed-up ramp is enabled by defining BOSS_PATH_MOVE_ACCEL_EN.
module boss_path_move #(
    parameter int PIXEL_WIDTH  = 11,
    parameter int FRAC_BITS    = 6,
    parameter int INITIAL_X    = 300,
    parameter int INITIAL_Y    = 200,
    parameter int X_SPEED      = 24,
    parameter int Y_SPEED      = 24,
    parameter int DIVE_SPEED   = 128,
    parameter int DIVE_FRAMES  = 30,
    parameter int MAX_SPEED    = 64,
    parameter int ACCEL_FRAMES = 60
) (
    input  logic             clk,
    input  logic             reset,
    boss_path_move_if.slave  bus
);
    localparam int POS_W = PIXEL_WIDTH + FRAC_BITS;
    localparam int CNT_W = $clog2(DIVE_FRAMES + 1);

    localparam logic signed [POS_W-1:0] INIT_X_FP = POS_W'(INITIAL_X << FRAC_BITS);
    localparam logic signed [POS_W-1:0] INIT_Y_FP = POS_W'(INITIAL_Y << FRAC_BITS);
    localparam logic signed [POS_W-1:0] DIVE_STEP = POS_W'(DIVE_SPEED);
    localparam logic [CNT_W-1:0]        DIVE_LAST = CNT_W'(DIVE_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CRUISE = 2'd1,
        ST_DIVE   = 2'd2,
        ST_RETURN = 2'd3
    } mode_t;

    if (ACCEL_FRAMES < 1 || MAX_SPEED < X_SPEED || MAX_SPEED < Y_SPEED) begin : g_bad_cfg
        $error("boss_path_move: speed-up ceiling or period misconfigured");
    end

    mode_t                    mode_q, mode_d;
    logic signed [POS_W-1:0]  pos_x_q, pos_x_d;
    logic signed [POS_W-1:0]  pos_y_q, pos_y_d;
    logic signed [POS_W-1:0]  saved_y_q, saved_y_d;
    logic                     dir_x_q, dir_x_d;   // 1 = moving toward -inf
    logic                     dir_y_q, dir_y_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [POS_W-1:0]  spd_x, spd_y;

    logic hit_left, hit_top, hit_right, hit_bottom;
    logic [CNT_W-1:0]         cnt_inc;
    logic signed [POS_W-1:0]  y_up;

    assign hit_left   = bus.border_collision & bus.HitEdgeCode[3];
    assign hit_top    = bus.border_collision & bus.HitEdgeCode[2];
    assign hit_right  = bus.border_collision & bus.HitEdgeCode[1];
    assign hit_bottom = bus.border_collision & bus.HitEdgeCode[0];
    assign cnt_inc    = cnt_q + 1'b1;
    assign y_up       = pos_y_q - DIVE_STEP;

`ifdef BOSS_PATH_MOVE_ACCEL_EN
    localparam int ACC_W = $clog2(ACCEL_FRAMES + 1);
    localparam logic signed [POS_W-1:0] MAX_SPD = POS_W'(MAX_SPEED);

    logic [ACC_W-1:0]        acc_cnt_q;
    logic signed [POS_W-1:0] spd_x_q, spd_y_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_cnt_q <= '0;
            spd_x_q   <= POS_W'(X_SPEED);
            spd_y_q   <= POS_W'(Y_SPEED);
        end else if (bus.enable && mode_q == ST_CRUISE && bus.startOfFrame) begin
            if (acc_cnt_q == ACC_W'(ACCEL_FRAMES - 1)) begin
                acc_cnt_q <= '0;
                if (spd_x_q < MAX_SPD) spd_x_q <= spd_x_q + 1'b1;
                if (spd_y_q < MAX_SPD) spd_y_q <= spd_y_q + 1'b1;
            end else begin
                acc_cnt_q <= acc_cnt_q + 1'b1;
            end
        end
    end

    assign spd_x = spd_x_q;
    assign spd_y = spd_y_q;
`else
    assign spd_x = POS_W'(X_SPEED);
    assign spd_y = POS_W'(Y_SPEED);
`endif

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
        mode_d    = mode_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        saved_y_d = saved_y_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        cnt_d     = cnt_q;

        if (bus.enable) begin
            unique case (mode_q)
                ST_IDLE: mode_d = ST_CRUISE;

                ST_CRUISE: begin
                    if (bus.startOfFrame) begin
                        pos_x_d = dir_x_q ? pos_x_q - spd_x : pos_x_q + spd_x;
                        pos_y_d = dir_y_q ? pos_y_q - spd_y : pos_y_q + spd_y;
                    end
                    // Edge contact forces direction away from that edge, overriding any switch.
                    if (hit_left)        dir_x_d = 1'b0;
                    else if (hit_right)  dir_x_d = 1'b1;
                    else if (bus.switch_direction_pulse && !bus.dive_request && !bus.random_axis)
                        dir_x_d = ~dir_x_q;
                    if (hit_top)         dir_y_d = 1'b0;
                    else if (hit_bottom) dir_y_d = 1'b1;
                    else if (bus.switch_direction_pulse && !bus.dive_request && bus.random_axis)
                        dir_y_d = ~dir_y_q;
                    if (bus.dive_request) begin
                        mode_d    = ST_DIVE;
                        saved_y_d = pos_y_q;
                        cnt_d     = '0;
                    end
                end

                ST_DIVE: begin
                    if (bus.startOfFrame) begin
                        pos_y_d = pos_y_q + DIVE_STEP;
                        cnt_d   = cnt_inc;
                        if (cnt_inc == DIVE_LAST) mode_d = ST_RETURN;
                    end
                    if (hit_bottom) mode_d = ST_RETURN;
                end

                ST_RETURN: begin
                    if (hit_top) begin
                        mode_d  = ST_CRUISE;
                        dir_y_d = 1'b0;
                    end else if (bus.startOfFrame) begin
                        if (y_up <= saved_y_q) begin
                            pos_y_d = saved_y_q;
                            mode_d  = ST_CRUISE;
                            dir_y_d = 1'b1;
                        end else begin
                            pos_y_d = y_up;
                        end
                    end
                end

                default: mode_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            mode_q    <= ST_IDLE;
            pos_x_q   <= INIT_X_FP;
            pos_y_q   <= INIT_Y_FP;
            saved_y_q <= '0;
            dir_x_q   <= 1'b0;
            dir_y_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            mode_q    <= mode_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            saved_y_q <= saved_y_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.topLeftX = pos_x_q[POS_W-1:FRAC_BITS];
    assign bus.topLeftY = pos_y_q[POS_W-1:FRAC_BITS];
    assign bus.mode     = mode_q;
    assign bus.diving   = (mode_q == ST_DIVE) || (mode_q == ST_RETURN);
endmodule

// File: doc/boss_path_move.md
Name: boss_path_move

Overview:
Parametrised successor to the boss motion block. It generates the boss sprite's top-left pixel coordinates with fractional sub-pixel precision, bouncing off screen borders and reversing a randomly chosen axis on a pulse. It adds a mode FSM (idle, cruise, dive, return) so the boss can swoop toward the player and climb back to its cruise altitude. It sits between the boss control logic (shoot/dive triggers, random source) and the boss bitmap/draw block.

Parameters:
PIXEL_WIDTH, 11, width of output coordinates (signed).
FRAC_BITS, 6, fractional bits of internal position; position width = PIXEL_WIDTH+FRAC_BITS.
INITIAL_X, 300, reset X in pixels.
INITIAL_Y, 200, reset Y in pixels.
X_SPEED, 24, cruise X step magnitude per frame in 1/2^FRAC_BITS pixel.
Y_SPEED, 24, cruise Y step magnitude per frame.
DIVE_SPEED, 128, Y step magnitude per frame in DIVE/RETURN.
DIVE_FRAMES, 30, maximum number of frames spent in DIVE.
MAX_SPEED, 64, speedup ceiling (optional feature only).
ACCEL_FRAMES, 60, frames per speedup step (optional feature only).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  motion enable; low freezes position and FSM
startOfFrame  in  1  one-cycle pulse per frame; the only cycle in which position changes
border_collision  in  1  boss touches a border this cycle
HitEdgeCode  in  4  [3]=left, [2]=top, [1]=right, [0]=bottom
switch_direction_pulse  in  1  request to reverse one axis
random_axis  in  1  1: reverse Y; 0: reverse X
dive_request  in  1  start-dive pulse
topLeftX  out  PIXEL_WIDTH  signed X pixel
topLeftY  out  PIXEL_WIDTH  signed Y pixel
mode  out  2  0=IDLE, 1=CRUISE, 2=DIVE, 3=RETURN
diving  out  1  high in DIVE or RETURN

Behaviour:
- Reset (sync, clk edge with reset=1): posX=INITIAL_X<<FRAC_BITS, posY=INITIAL_Y<<FRAC_BITS, dirX=dirY=+, mode=IDLE, frame counter=0, saved_y=0, outputs reflect the reset position on the next cycle. Reset overrides all inputs, including mid-dive.
- Outputs: topLeftX/Y = pos >>> FRAC_BITS (arithmetic shift, floor toward -inf), truncated to PIXEL_WIDTH; registered-state derived, no combinational input paths.
- enable=0: no position, direction or counter change; mode held; pulses are ignored, not queued.
- IDLE: position held; enable=1 -> CRUISE next cycle.
- CRUISE: on startOfFrame pos += dir*speed on each axis, using the direction registered before that edge.
  - switch_direction_pulse flips dirY (random_axis=1) or dirX (0).
  - Border: top&&dirY<0 or bottom&&dirY>0 -> flip Y; left&&dirX<0 or right&&dirX>0 -> flip X.
  - Border and switch on the same axis in the same cycle: border wins (direction set away from the edge, never toward it).
  - dive_request -> DIVE; saved_y=posY; counter=0. Takes precedence over a same-cycle switch pulse; border handling still applies.
- DIVE: X frozen; on startOfFrame posY += DIVE_SPEED and counter++. Exit to RETURN when counter reaches DIVE_FRAMES or when bottom edge is hit (border_collision && HitEdgeCode[0]). dive_request/switch ignored.
- RETURN: on startOfFrame posY -= DIVE_SPEED; if the result is <= saved_y, posY=saved_y exactly and mode -> CRUISE with dirY=- (up). Top edge in RETURN: posY held, -> CRUISE.
- Width: signed arithmetic at PIXEL_WIDTH+FRAC_BITS; no saturation; wrap is permitted only if parameters are misconfigured.

Optional Feature:
BOSS_PATH_MOVE_ACCEL_EN: when defined, every ACCEL_FRAMES startOfFrame pulses spent in CRUISE increments both cruise speed magnitudes by 1, saturating at MAX_SPEED. Speeds reset to X_SPEED/Y_SPEED on reset only; the counter pauses outside CRUISE. When undefined, cruise speeds are constant X_SPEED/Y_SPEED and there is no extra logic.

Test Plan:
- Reset, enable=1, 8 startOfFrame pulses, no collisions -> mode=1, topLeftX=303 (19200+192=19392), topLeftY=203.
- Right edge: border_collision=1 with HitEdgeCode=4'b0010 while dirX=+ -> next frame topLeftX decreases. Repeat with dirX=- -> direction unchanged.
- switch_direction_pulse with random_axis=1 and top-edge collision in the same cycle, dirY=- -> dirY=+ (border wins).
- dive_request at Y=200 -> mode=2; after 30 frames Y=200+30*2=260, mode=3; 30 more frames -> Y=200, mode=1, dirY up.
- Bottom edge hit at DIVE frame 5 -> mode=3 next cycle; Y returns to and snaps at saved_y.
- enable=0 for 10 frames during DIVE -> position and counter unchanged. reset=1 mid-RETURN -> (300,200), mode=0.
